// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised UART transmitter. Serialises DATA_BITS-wide words LSB first,
// framed by one start bit, an optional parity bit and one or two stop bits.
// The bit period is generated internally from CLK_HZ / BAUD_RATE, so no
// external baud tick is needed.
//
// Optional feature macro: UART_TX_FIFO_EN
//   defined   : a FIFO_DEPTH-entry word FIFO sits ahead of the shifter, ready
//               reflects FIFO space and queued words go out back-to-back.
//   undefined : no storage; ready is high only while the transmitter is idle
//               and FIFO_DEPTH has no functional effect.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD_RATE   line rate; bit period BIT_CYC = CLK_HZ / BAUD_RATE (>= 2)
//   DATA_BITS   payload width, 5..9
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   1 or 2
//   FIFO_DEPTH  power of two >= 2 (FIFO build only)
//
// Ports:
//   clock       single clock, rising edge
//   reset_n     asynchronous active-low reset; aborts any frame at once
//   send        producer offers data this cycle
//   data        word to transmit
//   ready       a word is accepted on any edge where send && ready
//   tx          serial line, idle high, registered
//   busy        a frame is in progress
//   frame_done  one-cycle pulse after the last stop-bit period ends
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned BIT_CYC = CLK_HZ / BAUD_RATE;
  localparam int unsigned CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int unsigned IDX_W   = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam bit               PAR_EN    = (PARITY != 0);
  localparam bit               PAR_ODD   = (PARITY == 1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks. FIFO_DEPTH is validated in both builds
  // so a parameter set stays legal when the FIFO is switched on later.
  // ---------------------------------------------------------------------------
  if (BIT_CYC < 2) begin : g_bad_baud
    $error("uart_tx_param: CLK_HZ / BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // FSM state and registered outputs
  state_e               state_q,   state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;  // cycle within the current bit period
  logic [IDX_W-1:0]     idx_q,     idx_d;      // data-bit or stop-bit index
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 par_q,     par_d;      // parity bit latched at frame start
  logic                 tx_q,      tx_d;
  logic                 busy_q;
  logic                 frame_done_q, frame_done_d;

  // Word source, provided either by the FIFO or straight from the port
  logic                 start_avail;  // a word can start a frame this edge
  logic [DATA_BITS-1:0] start_word;
  logic                 load;         // the FSM takes start_word this edge

  logic                 bit_end;

  assign bit_end = (bit_cnt_q == BIT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    frame_done_d = 1'b0;
    load         = 1'b0;

    // The bit-period counter free-runs in every non-idle state and wraps at
    // each bit boundary; in IDLE it rests at zero.
    if (state_q != S_IDLE) begin
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_avail) begin
          load = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            frame_done_d = 1'b1;
            idx_d        = '0;
            // A queued word chains straight into the next start bit.
            if (start_avail) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Frame start: capture the payload and its parity so later changes on the
    // source cannot disturb the frame in flight.
    if (load) begin
      state_d   = S_START;
      bit_cnt_d = '0;
      shift_d   = start_word;
      par_d     = (^start_word) ^ PAR_ODD;
    end

    // tx is derived from the next state so the line level changes on the same
    // edge as the state it belongs to.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tx_q         <= tx_d;
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef UART_TX_FIFO_EN
  // ---------------------------------------------------------------------------
  // Transmit FIFO. ready comes from the registered count only, so it never
  // depends combinationally on send.
  // ---------------------------------------------------------------------------
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [FCNT_W-1:0]    fifo_cnt_q;
  logic                 push;

  assign ready       = (fifo_cnt_q != FIFO_FULL);
  assign push        = send && ready;
  assign start_avail = (fifo_cnt_q != '0);
  assign start_word  = fifo_mem[rd_ptr_q];

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= data;
    end
  end

  // Pointers are exactly log2(depth) wide, so they wrap modulo FIFO_DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, load})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;  // idle, or push and pop together
      endcase
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Direct path: a word is taken straight from the port, and only while the
  // transmitter is idle. ready_q mirrors (state == IDLE) as a register.
  // ---------------------------------------------------------------------------
  logic ready_q;

  assign ready       = ready_q;
  assign start_avail = send && ready_q;
  assign start_word  = data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d == S_IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
//
// Directed bench for uart_tx_param. Four instances share one clock and reset:
//   [0] 8N1  [1] 8E1  [2] 8O1  [3] 9N2, all at BIT_CYC = 1600 / 100 = 16.
// Expected line levels are given per bit period as hand-built vectors
// (bit p of the vector is the tx level during bit period p of the frame).
// When UART_TX_FIFO_EN is defined the FIFO scenario replaces the scenarios
// that depend on ready being low during a frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

  localparam int BIT_CYC = 16;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;  // accept edge to start bit: push, then pop
`else
  localparam int LAT = 1;
`endif

  logic       clock;
  logic       reset_n;
  logic       send_v  [4];
  logic [8:0] data_v  [4];
  logic       ready_v [4];
  logic       tx_v    [4];
  logic       busy_v  [4];
  logic       fd_v    [4];

  int n_pass;
  int n_total;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  uart_tx_param #(
    .CLK_HZ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8n1 (
    .clock(clock), .reset_n(reset_n), .send(send_v[0]), .data(data_v[0][7:0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0])
  );

  uart_tx_param #(
    .CLK_HZ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8e1 (
    .clock(clock), .reset_n(reset_n), .send(send_v[1]), .data(data_v[1][7:0]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1])
  );

  uart_tx_param #(
    .CLK_HZ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8o1 (
    .clock(clock), .reset_n(reset_n), .send(send_v[2]), .data(data_v[2][7:0]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2])
  );

  uart_tx_param #(
    .CLK_HZ(1600), .BAUD_RATE(100), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_9n2 (
    .clock(clock), .reset_n(reset_n), .send(send_v[3]), .data(data_v[3]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(fd_v[3])
  );

  // ---------------------------------------------------------------------------
  // Reset values on every instance
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2 reset_n = 1'b0;
    #12;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (tx_v[k] !== 1'b1) $display("FAIL reset tx[%0d]: got %b want 1", k, tx_v[k]);
      else n_pass++;
      n_total++;
      if (ready_v[k] !== 1'b1) $display("FAIL reset ready[%0d]: got %b want 1", k, ready_v[k]);
      else n_pass++;
      n_total++;
      if (busy_v[k] !== 1'b0) $display("FAIL reset busy[%0d]: got %b want 0", k, busy_v[k]);
      else n_pass++;
      n_total++;
      if (fd_v[k] !== 1'b0) $display("FAIL reset frame_done[%0d]: got %b want 0", k, fd_v[k]);
      else n_pass++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    n_total++;
    if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0)
      $display("FAIL reset idle after release: got tx=%b busy=%b want tx=1 busy=0", tx_v[0], busy_v[0]);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // One frame: send a word for one cycle and check the line level in every bit
  // period, the idle line around it, busy length/position, the frame_done
  // pulse and ready. With intrude set, send is raised mid-frame with 0xFF; it
  // must be ignored and no second frame may follow.
  // ---------------------------------------------------------------------------
  task automatic run_frame(input int k, input logic [8:0] word, input logic [15:0] exp_bits,
                           input int nper, input string name, input bit intrude);
    int          total;
    int          busy_cnt;
    int          busy_first;
    int          rdy_low;
    int          fd_cnt;
    int          fd_at;
    int          bad_idle;
    int          f;
    int          exp_rdy_low;
    logic [15:0] bad_per;
    logic [15:0] got_mid;
    logic        exp_tx;

    total      = nper * BIT_CYC;
    busy_cnt   = 0;
    busy_first = -1000;
    rdy_low    = 0;
    fd_cnt     = 0;
    fd_at      = -1000;
    bad_idle   = 0;
    bad_per    = '0;
    got_mid    = '0;
`ifdef UART_TX_FIFO_EN
    exp_rdy_low = 0;
`else
    exp_rdy_low = total;
`endif

    @(negedge clock);
    data_v[k] = word;
    send_v[k] = 1'b1;
    @(negedge clock);
    send_v[k] = 1'b0;
    data_v[k] = ~word;  // must not reach the line: payload was captured

    for (int c = 0; c < total + LAT + 40; c++) begin
      f = c - (LAT - 1);
      exp_tx = (f >= 0 && f < total) ? exp_bits[f / BIT_CYC] : 1'b1;
      if (f >= 0 && f < total && (f % BIT_CYC) == 8) got_mid[f / BIT_CYC] = tx_v[k];
      if (tx_v[k] !== exp_tx) begin
        if (f >= 0 && f < total) bad_per[f / BIT_CYC] = 1'b1;
        else bad_idle++;
      end
      if (busy_v[k] === 1'b1) begin
        busy_cnt++;
        if (busy_first == -1000) busy_first = f;
      end
      if (fd_v[k] === 1'b1) begin
        fd_cnt++;
        fd_at = f;
      end
      if (ready_v[k] !== 1'b1) rdy_low++;
      if (intrude) begin
        if (f == 40) begin
          send_v[k] = 1'b1;
          data_v[k] = 9'h0FF;
        end
        if (f == 43) send_v[k] = 1'b0;
      end
      @(negedge clock);
    end

    for (int p = 0; p < nper; p++) begin
      n_total++;
      if (bad_per[p])
        $display("FAIL %s tx bit period %0d: got %b (mid-period) want %b throughout", name, p, got_mid[p], exp_bits[p]);
      else n_pass++;
    end
    n_total++;
    if (bad_idle != 0) $display("FAIL %s idle tx: got %0d low cycles want 0", name, bad_idle);
    else n_pass++;
    n_total++;
    if (busy_cnt != total) $display("FAIL %s busy length: got %0d want %0d", name, busy_cnt, total);
    else n_pass++;
    n_total++;
    if (busy_first != 0) $display("FAIL %s busy start: got frame cycle %0d want 0", name, busy_first);
    else n_pass++;
    n_total++;
    if (fd_cnt != 1) $display("FAIL %s frame_done count: got %0d want 1", name, fd_cnt);
    else n_pass++;
    n_total++;
    if (fd_at != total) $display("FAIL %s frame_done position: got %0d want %0d", name, fd_at, total);
    else n_pass++;
    n_total++;
    if (rdy_low != exp_rdy_low) $display("FAIL %s ready low cycles: got %0d want %0d", name, rdy_low, exp_rdy_low);
    else n_pass++;
  endtask

`ifndef UART_TX_FIFO_EN
  // ---------------------------------------------------------------------------
  // send held high across a frame boundary without a FIFO: the second word is
  // taken one cycle after ready returns, leaving exactly one idle cycle.
  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    @(negedge clock);
    data_v[0] = 9'h055;
    send_v[0] = 1'b1;
    @(negedge clock);                  // c = 0, first frame cycle
    repeat (160) @(negedge clock);     // c = 160: the single idle cycle
    n_total++;
    if (fd_v[0] !== 1'b1) $display("FAIL b2b frame_done at gap: got %b want 1", fd_v[0]);
    else n_pass++;
    n_total++;
    if (tx_v[0] !== 1'b1) $display("FAIL b2b tx at gap: got %b want 1", tx_v[0]);
    else n_pass++;
    n_total++;
    if (busy_v[0] !== 1'b0) $display("FAIL b2b busy at gap: got %b want 0", busy_v[0]);
    else n_pass++;
    n_total++;
    if (ready_v[0] !== 1'b1) $display("FAIL b2b ready at gap: got %b want 1", ready_v[0]);
    else n_pass++;
    @(negedge clock);                  // c = 161: second start bit
    n_total++;
    if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || ready_v[0] !== 1'b0)
      $display("FAIL b2b second start: got tx=%b busy=%b ready=%b want tx=0 busy=1 ready=0",
               tx_v[0], busy_v[0], ready_v[0]);
    else n_pass++;
    send_v[0] = 1'b0;
    repeat (24) @(negedge clock);      // c = 185: data bit 0 of 0x55
    n_total++;
    if (tx_v[0] !== 1'b1) $display("FAIL b2b second data bit0: got %b want 1", tx_v[0]);
    else n_pass++;
    repeat (16) @(negedge clock);      // c = 201: data bit 1 of 0x55
    n_total++;
    if (tx_v[0] !== 1'b0) $display("FAIL b2b second data bit1: got %b want 0", tx_v[0]);
    else n_pass++;
    repeat (120) @(negedge clock);     // c = 321: after second STOP end edge
    n_total++;
    if (fd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1)
      $display("FAIL b2b second end: got fd=%b busy=%b tx=%b want fd=1 busy=0 tx=1",
               fd_v[0], busy_v[0], tx_v[0]);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (fd_v[0] !== 1'b0) $display("FAIL b2b frame_done width: got %b want 0", fd_v[0]);
    else n_pass++;
  endtask
`endif

`ifdef UART_TX_FIFO_EN
  // ---------------------------------------------------------------------------
  // FIFO: send held 6 cycles with 0x11..0x16 from idle. Five words fit (one is
  // popped on the second edge), the sixth is refused; five frames follow with
  // no idle gap and frame_done every 160 cycles.
  // ---------------------------------------------------------------------------
  task automatic test_fifo();
    int         fd_cnt;
    int         fd_bad;
    int         gap;
    int         r;
    int         j;
    int         w;
    logic [7:0] got [5];

    fd_cnt = 0;
    fd_bad = 0;
    gap    = 0;
    for (int i = 0; i < 5; i++) got[i] = 8'h00;

    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      send_v[0] = 1'b1;
      data_v[0] = 9'(8'h11 + i);
      #1;
      n_total++;
      if (ready_v[0] !== (i < 5)) $display("FAIL fifo ready cycle %0d: got %b want %b", i, ready_v[0], (i < 5));
      else n_pass++;
      @(negedge clock);
    end
    send_v[0] = 1'b0;                 // c = 5 (c = 0 after the first push edge)

    for (int c = 5; c < 1000; c++) begin
      if (fd_v[0] === 1'b1) begin
        if (fd_cnt < 5 && c != 161 + 160 * fd_cnt) fd_bad++;
        fd_cnt++;
      end
      if (c >= 1 && c <= 800 && busy_v[0] !== 1'b1) gap++;
      if (c >= 1) begin
        r = c - 1;
        j = r / 160;
        w = r % 160;
        if (j < 5 && (w % 16) == 8 && (w / 16) >= 1 && (w / 16) <= 8) got[j][(w / 16) - 1] = tx_v[0];
      end
      @(negedge clock);
    end

    n_total++;
    if (fd_cnt != 5) $display("FAIL fifo frame_done count: got %0d want 5", fd_cnt);
    else n_pass++;
    n_total++;
    if (fd_bad != 0) $display("FAIL fifo frame_done spacing: got %0d misplaced want 0", fd_bad);
    else n_pass++;
    n_total++;
    if (gap != 0) $display("FAIL fifo idle gaps: got %0d busy-low cycles want 0", gap);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (got[i] !== 8'(8'h11 + i)) $display("FAIL fifo word %0d: got %h want %h", i, got[i], 8'(8'h11 + i));
      else n_pass++;
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Reset in the 3rd data bit: outputs return to idle before the next edge and
  // nothing is sent afterwards.
  // ---------------------------------------------------------------------------
  task automatic test_reset_abort();
    int tx_low;
    int busy_hi;

    @(negedge clock);
    data_v[0] = 9'h000;
    send_v[0] = 1'b1;
    @(negedge clock);
    send_v[0] = 1'b0;
    repeat (50 + LAT - 1) @(negedge clock);  // frame cycle 50: data bit 2
    n_total++;
    if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1)
      $display("FAIL abort pre-reset: got tx=%b busy=%b want tx=0 busy=1", tx_v[0], busy_v[0]);
    else n_pass++;

    #2 reset_n = 1'b0;
    #1;                                      // still 2 time units before the next rising edge
    n_total++;
    if (tx_v[0] !== 1'b1) $display("FAIL abort tx: got %b want 1", tx_v[0]);
    else n_pass++;
    n_total++;
    if (busy_v[0] !== 1'b0) $display("FAIL abort busy: got %b want 0", busy_v[0]);
    else n_pass++;
    n_total++;
    if (ready_v[0] !== 1'b1) $display("FAIL abort ready: got %b want 1", ready_v[0]);
    else n_pass++;
    n_total++;
    if (fd_v[0] !== 1'b0) $display("FAIL abort frame_done: got %b want 0", fd_v[0]);
    else n_pass++;

    @(negedge clock);
    reset_n = 1'b1;
    tx_low  = 0;
    busy_hi = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (tx_v[0] !== 1'b1) tx_low++;
      if (busy_v[0] !== 1'b0) busy_hi++;
    end
    n_total++;
    if (tx_low != 0) $display("FAIL abort quiet tx: got %0d low cycles want 0", tx_low);
    else n_pass++;
    n_total++;
    if (busy_hi != 0) $display("FAIL abort quiet busy: got %0d busy cycles want 0", busy_hi);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_v[k] = 1'b0;
      data_v[k] = 9'h000;
    end

    test_reset();
    // 0xA5 LSB first: 1,0,1,0,0,1,0,1 between start 0 and stop 1
    run_frame(0, 9'h0A5, 16'h034A, 10, "8N1_A5", 1'b0);
    // 0x07: three ones -> even parity bit 1, odd parity bit 0
    run_frame(1, 9'h007, 16'h060E, 11, "8E1_07", 1'b0);
    run_frame(2, 9'h007, 16'h040E, 11, "8O1_07", 1'b0);
    // 0x1FF: nine ones, then two stop periods (32 high cycles)
    run_frame(3, 9'h1FF, 16'h0FFE, 12, "9N2_1FF", 1'b0);
`ifdef UART_TX_FIFO_EN
    run_frame(0, 9'h03C, 16'h0278, 10, "8N1_3C", 1'b0);
    test_fifo();
`else
    // 0x3C mid-frame send of 0xFF while ready is low must be ignored
    run_frame(0, 9'h03C, 16'h0278, 10, "8N1_3C_busy_send", 1'b1);
    test_back_to_back();
`endif
    test_reset_abort();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: the next-generation replacement for the fixed 9-bit, 9600-baud transmitter. Serialises words of configurable width with optional parity and one or two stop bits. Has an integrated bit-period counter, so it needs no external baud generator. An optional transmit FIFO decouples the producer and sends frames back-to-back. Sits between the ATC command/response logic (producer) and the board `tx` pin.

## Interface
- `CLK_HZ`, default 25000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate; bit period `BIT_CYC = CLK_HZ / BAUD_RATE` (integer floor, must be ≥ 2).
- `DATA_BITS`, default 8: payload width, legal 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal 1 or 2.
- `FIFO_DEPTH`, default 4: power of two ≥ 2; used only with `UART_TX_FIFO_EN`.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `send` in 1: producer offers `data` this cycle.
- `data` in `DATA_BITS`: word to transmit, sent LSB first.
- `ready` out 1: block accepts a word this cycle; a transfer occurs on any edge where `send && ready`.
- `tx` out 1: serial line, idle high; registered.
- `busy` out 1: a frame is in progress (any state other than IDLE).
- `frame_done` out 1: one-cycle pulse in the cycle after the last stop-bit period ends.

## Operation
- Reset values: `tx`=1, `ready`=1, `busy`=0, `frame_done`=0. State is IDLE, counters are 0, and the FIFO is empty.
- Asserting `reset_n` low mid-frame aborts the frame immediately, without waiting for a clock edge. After release, the block transmits nothing until a new word is accepted.
- FSM states: IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE or START.
  - Each state holds for `BIT_CYC` cycles, counted by `bit_cnt` (0..`BIT_CYC`-1). The state advances when `bit_cnt` = `BIT_CYC`-1.
  - DATA repeats for `DATA_BITS` periods; the index counter has width `$clog2(DATA_BITS+1)`.
  - STOP lasts `STOP_BITS` periods.
- `tx` levels: START drives 0. DATA drives the shift-register LSB; the register shifts right at each bit boundary. PARITY drives the XOR of the payload (inverted for odd parity). STOP and IDLE drive 1.
- Frame length: `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × BIT_CYC` cycles.
- Payload is captured into the shift register at frame start. Changes on `data` after acceptance have no effect.
- `send` while `ready`=0 is ignored: no state change and no data captured.

## Timing
- No FIFO: `ready` = (state==IDLE).
  - Accept at edge N puts `tx`=0 after edge N.
  - `ready` drops after edge N and returns after the edge ending STOP.
  - There is a minimum of one IDLE cycle between frames.
- FIFO: `ready` = !full, where full is taken from the registered count.
  - Push at edge N; pop and enter START at edge N+1; `tx`=0 after edge N+1, giving 2 cycles of latency.
  - When the FIFO is non-empty at the STOP end edge, the FSM goes straight to START. There is no idle gap.
  - A push and a pop on the same edge leave the count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- `frame_done` is high for exactly 1 cycle per frame, including back-to-back frames.
- `busy` is high from the START entry edge through the STOP end edge.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - A `FIFO_DEPTH`-entry FIFO of `DATA_BITS`-wide words sits ahead of the shifter.
  - `ready` reflects FIFO space, so words can be accepted during a frame.
- `UART_TX_FIFO_EN` undefined:
  - No FIFO storage is built.
  - `ready` is high only in IDLE, and `FIFO_DEPTH` is ignored.

## Test plan
Common setup: `CLK_HZ`=1600 and `BAUD_RATE`=100, giving `BIT_CYC`=16.
- 8N1, `send` `data`=0xA5 for one cycle.
  - `tx` sequence, 16 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` high for 160 cycles; one `frame_done` pulse; `ready` low for the whole frame (no FIFO).
- 8E1, `data`=0x07.
  - Parity bit = 1; frame is 176 cycles.
  - Repeat with 8O1: parity bit = 0.
- 9N2, `data`=0x1FF.
  - Nine data bits of 1, then `tx` high for 32 stop cycles.
  - Total 192 cycles before `frame_done`.
- `UART_TX_FIFO_EN`, `FIFO_DEPTH`=4, `send` held 6 consecutive cycles from idle with 0x11..0x16.
  - 0x11–0x15 accepted; `ready` low in the 6th cycle, so 0x16 is refused.
  - Five frames back-to-back with no idle cycles; 5 `frame_done` pulses 160 cycles apart.
- `reset_n` low in the 3rd data bit of a frame.
  - `tx`=1, `busy`=0, `ready`=1 before the next clock edge.
  - After release, `tx` stays 1 for 200 cycles with `send`=0.
- `send` asserted while `ready`=0 (no FIFO, mid-frame, `data`=0xFF).
  - The current frame completes unchanged and no second frame follows.
